// File: rtl/tempsens_pkg.sv
// Shared types and default sizing for the temperature-sensor scheduler.
package tempsens_pkg;
  localparam int DEF_CNT_W   = 28;
  localparam int DEF_DATA_W  = 12;
  localparam int DEF_TIMEOUT = 1_000_000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_CAPTURE
  } state_e;
endpackage

// File: rtl/tempsens_sched_tick_gen.sv
// Period counter: registered one-cycle tick every max(period,2) cycles while enabled.
module tick_gen
  import tempsens_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);
  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic [CNT_W-1:0] w_last;
  logic             w_hit;

  // periods below 2 are clamped so the counter always has a distinct wrap point
  assign w_last = (period < CNT_W'(2)) ? CNT_W'(1) : period - CNT_W'(1);
  assign w_hit  = (r_cnt == w_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (!enable) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_hit;
      r_cnt  <= w_hit ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // a tick already in flight is suppressed if enable drops that cycle
  assign tick = r_tick & enable;
endmodule

// File: rtl/tempsens_sched.sv
// Conversion scheduler: coalesces periodic/manual requests, drives the sensor
// handshake with a timeout, and tracks sticky error and overrun counts.
module tempsens_sched
  import tempsens_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [CNT_W-1:0]  period,
  input  logic              manual_req,
  input  logic              clear_err,
  output logic              sensor_start,
  input  logic              sensor_done,
  input  logic [DATA_W-1:0] sensor_data,
  output logic [DATA_W-1:0] temp_out,
  output logic              temp_valid,
  output logic              busy,
  output logic              timeout_err,
  output logic [7:0]        overrun_cnt
);
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e            r_state, w_state_nxt;
  logic              r_pending;
  logic [TO_W-1:0]   r_to_cnt;
  logic [DATA_W-1:0] r_temp;
  logic              r_terr;
  logic [7:0]        r_ovr;

  logic w_tick, w_req, w_enter_start, w_to_evt;

  tick_gen #(.CNT_W(CNT_W)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .period  (period),
    .tick    (w_tick)
  );

  assign w_req         = w_tick | manual_req;
  assign w_enter_start = (r_state == ST_IDLE) & r_pending;

  always_comb begin
    w_state_nxt = r_state;
    w_to_evt    = 1'b0;
    case (r_state)
      ST_IDLE:    if (r_pending) w_state_nxt = ST_START;
      ST_START:   w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        // done takes priority over a timeout landing on the same cycle
        if (sensor_done) begin
          w_state_nxt = ST_CAPTURE;
        end else if (r_to_cnt == TO_LAST) begin
          w_state_nxt = ST_IDLE;
          w_to_evt    = 1'b1;
        end
      end
      ST_CAPTURE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_pending <= 1'b0;
      r_to_cnt  <= '0;
      r_temp    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_enter_start)   r_pending <= 1'b0;
      else if (w_req)      r_pending <= 1'b1;
      r_to_cnt <= (r_state == ST_WAIT) ? r_to_cnt + TO_W'(1) : '0;
      if (r_state == ST_WAIT && sensor_done) r_temp <= sensor_data;
    end
  end

  // a request landing while one is still queued is lost and counted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_terr <= 1'b0;
      r_ovr  <= '0;
    end else if (clear_err) begin
      r_terr <= 1'b0;
      r_ovr  <= '0;
    end else begin
      if (w_to_evt) r_terr <= 1'b1;
      if (w_req && r_pending && r_ovr != 8'hFF) r_ovr <= r_ovr + 8'd1;
    end
  end

  assign sensor_start = (r_state == ST_START);
  assign temp_valid   = (r_state == ST_CAPTURE);
  assign busy         = (r_state != ST_IDLE);
  assign temp_out     = r_temp;
  assign timeout_err  = r_terr;
  assign overrun_cnt  = r_ovr;
endmodule

// File: tb/tb_tempsens_sched.sv
// Bench for tempsens_sched: two instances (short and long timeout) share stimulus
// and are each checked every cycle against a request/conversion model.
module tb_tempsens_sched;
  localparam int CW = 28;
  localparam int DW = 12;
  localparam int TA = 16;
  localparam int TB = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0, enable = 1'b0, manual_req = 1'b0, clear_err = 1'b0;
  logic [CW-1:0] period = '0;
  logic [DW-1:0] sensor_data = '0;
  logic done_a = 1'b0, done_b = 1'b0;
  logic start_a, valid_a, busy_a, terr_a, start_b, valid_b, busy_b, terr_b;
  logic [DW-1:0] tout_a, tout_b;
  logic [7:0] ovr_a, ovr_b;

  always #5 clk = ~clk;

  tempsens_sched #(.CNT_W(CW), .DATA_W(DW), .TIMEOUT(TA)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .period(period),
    .manual_req(manual_req), .clear_err(clear_err), .sensor_start(start_a),
    .sensor_done(done_a), .sensor_data(sensor_data), .temp_out(tout_a),
    .temp_valid(valid_a), .busy(busy_a), .timeout_err(terr_a), .overrun_cnt(ovr_a));

  tempsens_sched #(.CNT_W(CW), .DATA_W(DW), .TIMEOUT(TB)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .period(period),
    .manual_req(manual_req), .clear_err(clear_err), .sensor_start(start_b),
    .sensor_done(done_b), .sensor_data(sensor_data), .temp_out(tout_b),
    .temp_valid(valid_b), .busy(busy_b), .timeout_err(terr_b), .overrun_cnt(ovr_b));

  int n_tests = 0, n_fail = 0, cyc = 0;
  int delay = 3;
  bit stray_en = 1'b0, fix_data = 1'b1;
  logic [DW-1:0] data_fix = 12'h3C7;

  // st: 0 idle, 1 start, 2 wait, 3 capture
  typedef struct {
    int st; bit pend; int tocnt; bit terr; int ovr;
    logic [DW-1:0] tout; bit tq; logic [CW-1:0] cnt;
  } mdl_t;
  mdl_t m[2];
  int cd[2];

  function automatic mdl_t mzero();
    mdl_t z;
    z.st = 0; z.pend = 0; z.tocnt = 0; z.terr = 0; z.ovr = 0;
    z.tout = '0; z.tq = 0; z.cnt = '0;
    return z;
  endfunction

  function automatic mdl_t mstep(mdl_t s, bit rst_n, bit en, logic [CW-1:0] per,
                                 bit man, bit clr, bit dn, logic [DW-1:0] dat, int tmo);
    mdl_t n;
    bit req, to_ev;
    logic [CW-1:0] plen;
    if (!rst_n) return mzero();
    n = s;
    req = (s.tq && en) || man;
    plen = (per < CW'(2)) ? CW'(2) : per;
    if (en) begin
      n.tq  = (s.cnt == plen - CW'(1));
      n.cnt = n.tq ? '0 : s.cnt + CW'(1);
    end else begin
      n.tq = 0; n.cnt = '0;
    end
    to_ev = (s.st == 2) && !dn && (s.tocnt == tmo - 1);
    n.ovr  = clr ? 0 : ((req && s.pend && s.ovr < 255) ? s.ovr + 1 : s.ovr);
    n.terr = clr ? 1'b0 : (to_ev ? 1'b1 : s.terr);
    n.pend = (s.st == 0 && s.pend) ? 1'b0 : (req ? 1'b1 : s.pend);
    n.tocnt = 0;
    case (s.st)
      0: n.st = s.pend ? 1 : 0;
      1: n.st = 2;
      2: if (dn) begin n.st = 3; n.tout = dat; end
         else if (to_ev) n.st = 0;
         else begin n.st = 2; n.tocnt = s.tocnt + 1; end
      default: n.st = 0;
    endcase
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cmp(input int d, input logic st, input logic vl, input logic bs,
                     input logic [DW-1:0] to, input logic te, input logic [7:0] ov);
    chk($sformatf("dut%0d.sensor_start", d), 32'(st), 32'(m[d].st == 1));
    chk($sformatf("dut%0d.temp_valid", d), 32'(vl), 32'(m[d].st == 3));
    chk($sformatf("dut%0d.busy", d), 32'(bs), 32'(m[d].st != 0));
    chk($sformatf("dut%0d.temp_out", d), 32'(to), 32'(m[d].tout));
    chk($sformatf("dut%0d.timeout_err", d), 32'(te), 32'(m[d].terr));
    chk($sformatf("dut%0d.overrun_cnt", d), 32'(ov), 32'(m[d].ovr));
  endtask

  // the single per-cycle compare process; the model advances after each compare
  always @(negedge clk) begin
    if (!reset_n) begin m[0] = mzero(); m[1] = mzero(); end
    cmp(0, start_a, valid_a, busy_a, tout_a, terr_a, ovr_a);
    cmp(1, start_b, valid_b, busy_b, tout_b, terr_b, ovr_b);
    m[0] = mstep(m[0], reset_n, enable, period, manual_req, clear_err, done_a, sensor_data, TA);
    m[1] = mstep(m[1], reset_n, enable, period, manual_req, clear_err, done_b, sensor_data, TB);
  end

  // sensor responder: done arrives `delay` cycles after the (modelled) start pulse
  function automatic bit resp(int d);
    bit f = 1'b0;
    if (cd[d] > 0) begin
      cd[d]--;
      if (cd[d] == 0) f = 1'b1;
    end
    if (m[d].st == 1 && delay > 0) cd[d] = delay;
    if (stray_en && $urandom_range(19) == 0) f = 1'b1;
    return f;
  endfunction

  task automatic cycle();
    @(posedge clk); #2;
    cyc++;
    manual_req = 1'b0; clear_err = 1'b0;
    if (!reset_n) begin cd[0] = 0; cd[1] = 0; end
    sensor_data = fix_data ? data_fix : DW'($urandom);
    done_a = resp(0);
    done_b = resp(1);
  endtask

  task automatic wait_start(output int s);
    bit found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (start_a) begin found = 1'b1; break; end
    end
    chk("wait_start_a", 32'(found), 32'd1);
    s = cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, s, sl, vl, prev, ns, nv, tk;
    m[0] = mzero(); m[1] = mzero(); cd[0] = 0; cd[1] = 0;

    // reset state
    repeat (3) cycle();
    chk("reset.busy", 32'(busy_a), 32'd0);
    chk("reset.temp_out", 32'(tout_a), 32'd0);
    chk("reset.overrun", 32'(ovr_b), 32'd0);
    reset_n = 1'b1;
    repeat (2) cycle();

    // manual latency: start in cycle 2, done in cycle 6, valid in cycle 7
    delay = 4; data_fix = 12'h3C7;
    c0 = cyc; manual_req = 1'b1;
    sl = -1; vl = -1;
    for (int i = 1; i <= 9; i++) begin
      cycle();
      if (start_a && sl < 0) sl = cyc - c0;
      if (valid_a && vl < 0) vl = cyc - c0;
    end
    chk("manual.start_latency", 32'(sl), 32'd2);
    chk("manual.valid_latency", 32'(vl), 32'd7);
    chk("manual.temp_out", 32'(tout_a), 32'h3C7);

    // periodic run
    delay = 3; data_fix = 12'h1A5; period = CW'(10); enable = 1'b1;
    prev = -1; ns = 0; nv = 0;
    for (int i = 0; i < 65; i++) begin
      cycle();
      if (start_a) begin
        if (prev >= 0) chk("periodic.spacing", 32'(cyc - prev), 32'd10);
        prev = cyc; ns++;
      end
      if (valid_a) begin
        nv++;
        chk("periodic.temp_out", 32'(tout_a), 32'h1A5);
      end
    end
    chk("periodic.n_start", 32'(ns >= 5), 32'd1);
    chk("periodic.valid_per_conv", 32'(nv >= ns - 1), 32'd1);
    enable = 1'b0;
    repeat (10) cycle();

    // period 0 and 1 clamp to a 2-cycle tick
    delay = 1;
    for (int p = 0; p < 2; p++) begin
      enable = 1'b0;
      repeat (5) cycle();
      period = CW'(p); enable = 1'b1; tk = 0;
      for (int i = 0; i < 20; i++) begin
        cycle();
        if (dut_a.u_tick.tick) tk++;
      end
      chk($sformatf("tick.period%0d", p), 32'(tk), 32'd10);
    end
    enable = 1'b0;
    repeat (10) cycle();

    // timeout on the 16-cycle instance, then clear
    clear_err = 1'b1; cycle();
    delay = 0; data_fix = 12'h0F0;
    repeat (3) cycle();
    manual_req = 1'b1;
    wait_start(s);
    repeat (16) cycle();
    chk("timeout.busy_last_wait", 32'(busy_a), 32'd1);
    chk("timeout.err_before", 32'(terr_a), 32'd0);
    cycle();
    chk("timeout.busy_after", 32'(busy_a), 32'd0);
    chk("timeout.err_set", 32'(terr_a), 32'd1);
    clear_err = 1'b1; cycle();
    chk("timeout.err_cleared", 32'(terr_a), 32'd0);
    repeat (60) cycle();

    // done coincides with the final timeout cycle: capture wins
    clear_err = 1'b1; cycle();
    delay = 16; data_fix = 12'h5AB;
    manual_req = 1'b1;
    wait_start(s);
    repeat (17) cycle();
    chk("coincide.valid", 32'(valid_a), 32'd1);
    chk("coincide.err", 32'(terr_a), 32'd0);
    chk("coincide.temp_out", 32'(tout_a), 32'h5AB);
    repeat (5) cycle();

    // overrun saturation with a slow sensor
    clear_err = 1'b1; cycle();
    delay = 20; period = CW'(2); enable = 1'b1;
    repeat (900) cycle();
    chk("overrun.sat_b", 32'(ovr_b), 32'd255);
    chk("overrun.sat_a", 32'(ovr_a), 32'd255);
    clear_err = 1'b1; cycle();
    chk("overrun.clear_wins", 32'(ovr_b), 32'd0);
    enable = 1'b0;
    repeat (30) cycle();

    // reset in the middle of WAIT
    delay = 0; manual_req = 1'b1;
    wait_start(s);
    repeat (3) cycle();
    chk("rstwait.busy_before", 32'(busy_a), 32'd1);
    reset_n = 1'b0; #1;
    chk("rstwait.start", 32'(start_a), 32'd0);
    chk("rstwait.busy", 32'(busy_a), 32'd0);
    chk("rstwait.temp_out", 32'(tout_a), 32'd0);
    chk("rstwait.err", 32'(terr_a), 32'd0);
    chk("rstwait.overrun", 32'(ovr_a), 32'd0);
    cycle();
    reset_n = 1'b1;
    nv = 0;
    repeat (5) begin cycle(); if (valid_a || valid_b) nv++; end
    chk("rstwait.no_valid", 32'(nv), 32'd0);
    delay = 3; data_fix = 12'h777; manual_req = 1'b1;
    wait_start(s);
    repeat (4) cycle();
    chk("rstwait.resume_valid", 32'(valid_a), 32'd1);
    chk("rstwait.resume_data", 32'(tout_a), 32'h777);
    repeat (5) cycle();

    // randomized traffic
    stray_en = 1'b1; fix_data = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if ($urandom_range(49) == 0) enable = ~enable;
      if (!enable && $urandom_range(9) == 0) period = CW'($urandom_range(12));
      manual_req = ($urandom_range(7) == 0);
      clear_err  = ($urandom_range(99) == 0);
      if ($urandom_range(29) == 0) delay = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(24, 1));
      if (!reset_n) reset_n = 1'b1;
      else if ($urandom_range(599) == 0) reset_n = 1'b0;
    end
    reset_n = 1'b1;
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tempsens_sched.md
TEMPSENS_SCHED -- requirements
Module: tempsens_sched

Interface
REQ-001 The block SHALL have parameter CNT_W, default 28, meaning the width of the period counter.
REQ-002 The block SHALL have parameter DATA_W, default 12, meaning the width of a sensor result.
REQ-003 The block SHALL have parameter TIMEOUT, default 1_000_000, meaning the maximum number of cycles spent waiting for sensor_done.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  high allows periodic conversions.
REQ-007 period  in  CNT_W  number of cycles between periodic conversion requests.
REQ-008 manual_req  in  1  one-cycle on-demand conversion request.
REQ-009 clear_err  in  1  clears timeout_err and overrun_cnt.
REQ-010 sensor_start  out  1  one-cycle conversion start pulse to the sensor interface.
REQ-011 sensor_done  in  1  one-cycle completion pulse from the sensor.
REQ-012 sensor_data  in  DATA_W  result; valid only when sensor_done=1.
REQ-013 temp_out  out  DATA_W  last captured result.
REQ-014 temp_valid  out  1  one-cycle pulse when temp_out updates.
REQ-015 busy  out  1  high whenever the state is not IDLE.
REQ-016 timeout_err  out  1  sticky flag set when a conversion times out.
REQ-017 overrun_cnt  out  8  saturating count of requests lost to coalescing.

Function
REQ-018 Period tick: the counter SHALL count 0..P-1 while enable=1, where P=max(period,2); it SHALL emit a one-cycle tick when the count equals P-1 and then wrap to 0.
REQ-019 While enable=0 the counter SHALL be held at 0 and SHALL emit no tick; a change of period SHALL take effect at the next compare.
REQ-020 Pending flag: tick or manual_req SHALL set pending on the next edge.
REQ-021 pending SHALL be cleared on the edge on which the FSM enters START.
REQ-022 If tick and manual_req are both high, they SHALL count as one request.
REQ-023 A request arriving while pending=1 SHALL increment overrun_cnt by 1, saturating at 255.
REQ-024 A request arriving while busy=1 and pending=0 SHALL set pending with no overrun.
REQ-025 FSM states SHALL be IDLE, START, WAIT, CAPTURE.
REQ-026 IDLE->START when pending=1.
REQ-027 START: sensor_start=1 for exactly one cycle, then ->WAIT with the timeout counter at 0.
REQ-028 WAIT->CAPTURE on sensor_done=1, latching sensor_data into temp_out on that edge.
REQ-029 WAIT->IDLE when the timeout counter reaches TIMEOUT-1 without sensor_done, setting timeout_err.
REQ-030 CAPTURE: temp_valid=1 for one cycle, then ->IDLE.
REQ-031 Latency: manual_req high in cycle 0 from IDLE SHALL produce sensor_start=1 in cycle 2; sensor_done in cycle k SHALL produce temp_valid=1 in cycle k+1.
REQ-032 If sensor_done and timeout coincide, sensor_done SHALL win.
REQ-033 sensor_done outside WAIT SHALL be ignored, leaving temp_out unchanged.
REQ-034 clear_err=1 SHALL zero timeout_err and overrun_cnt on the next edge.
REQ-035 If clear_err coincides with a set or increment event, the clear SHALL win.
REQ-036 Dropping enable mid-conversion SHALL NOT abort it; an already-set pending SHALL still be serviced.

Reset
REQ-037 reset_n=0 SHALL asynchronously force state IDLE, counter 0, pending 0, and timeout counter 0.
REQ-038 reset_n=0 SHALL force sensor_start 0, temp_valid 0, busy 0, temp_out 0, timeout_err 0, and overrun_cnt 0.
REQ-039 Reset asserted mid-conversion SHALL abandon it with no temp_valid pulse.
REQ-040 The first tick after reset release SHALL occur P cycles after enable is first sampled high.

Structure
REQ-041 Package tempsens_pkg SHALL hold the FSM state enum, DATA_W, CNT_W, and the TIMEOUT default.
REQ-042 The period counter and tick logic SHALL be the sub-module tick_gen (ports clk, reset_n, enable, period, tick).
REQ-043 The FSM, pending flag, and error/overrun logic SHALL remain in tempsens_sched.

Verification
REQ-044 Periodic run: enable=1, period=10, sensor model replying with done 3 cycles after start and data=0x1A5 -> sensor_start every 10 cycles; temp_out=0x1A5 with a temp_valid pulse each conversion.
REQ-045 Manual latency: idle, enable=0, manual_req in cycle 0 -> sensor_start in cycle 2; done in cycle 6 -> temp_valid in cycle 7.
REQ-046 Timeout: TIMEOUT=16, no sensor_done -> timeout_err=1 and busy=0 after 16 WAIT cycles; clear_err then drives timeout_err=0.
REQ-047 Overrun: period=2 with the sensor taking 20 cycles -> overrun_cnt increments per lost tick and saturates at 255, with no further sensor_start until done.
REQ-048 Boundary: period=0 and period=1 -> tick every 2 cycles; sensor_done and timeout in the same cycle -> capture, timeout_err stays 0.
REQ-049 Reset mid-WAIT: reset_n low for 1 cycle -> all outputs 0 immediately, no temp_valid, and normal operation after release.
